framebuffer_scan_reader: RTL and testbench
==========================================

Name: framebuffer_scan_reader

Overview:
- Read-side master for the dual-port frame buffer.
- Scans a WIDTH x HEIGHT image in raster order from a base address.
- Drives the buffer's read port (addr_out, regread) and absorbs its 1-cycle read latency in a small FIFO.
- Presents pixels downstream on a valid/ready stream with end-of-line and end-of-frame flags. Feeds the display/processing stage.

Parameters:
AW, 15, address width; must match the frame buffer.
DW, 8, pixel data width; must match the frame buffer.
WIDTH, 160, pixels per line.
HEIGHT, 120, lines per frame.
BASE, 0, address of pixel (0,0); BASE+WIDTH*HEIGHT-1 must be < 2**AW (elaboration-time check, fatal otherwise).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  frame request; sampled only in IDLE.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse after the final pixel handshake.
addr_out  output  AW  read address to frame buffer; registered.
regread  output  1  read enable to frame buffer; registered.
data_in  input  DW  frame buffer read data; valid the cycle after regread=1.
px_data  output  DW  pixel value.
px_valid  output  1  pixel available.
px_ready  input  1  downstream accepts pixel.
px_eol  output  1  current pixel is last of its line.
px_last  output  1  current pixel is last of the frame.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; FIFO emptied; counters cleared; in-flight reads discarded.
- States:
  - IDLE: start=1 -> READ. Address counter = BASE; x = y = 0.
  - READ: issues reads. After the read for pixel WIDTH*HEIGHT-1 is issued -> DRAIN.
  - DRAIN: no reads issued. Final handshake (px_valid & px_ready & px_last) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy: 1 in READ, DRAIN and DONE; 0 in IDLE.
- start while busy: ignored. start held high in IDLE after DONE begins a new frame.
- Read issue:
  - regread=1 for a cycle only if FIFO entries plus reads not yet written into the FIFO is < 4, counting this cycle's pop.
  - The address increments by 1 per issued read; no wrap.
  - addr_out holds its last value when regread=0.
- Capture: data_in is written into the FIFO on the edge ending the cycle after the regread=1 cycle. eol and last flags are stored with the data.
- FIFO: 4 entries. Overflow is impossible by construction; an assertion checks this in simulation.
- Latency: with start sampled at edge t0:
  - regread=1, addr_out=BASE in cycle t0+1.
  - px_valid=1 with pixel 0 in cycle t0+3.
- Throughput: with px_ready held 1, one pixel per cycle sustained after the initial latency.
- Stream rules:
  - While px_valid=1 & px_ready=0, px_data, px_eol and px_last are held stable.
  - px_valid never drops without a handshake.
- Flags: px_eol=1 when pixel x==WIDTH-1. px_last=1 only for pixel (WIDTH-1, HEIGHT-1), which also carries px_eol=1.
- Outputs px_data, px_eol and px_last are 0 when px_valid=0.
- Width rules: x counter is clog2(WIDTH) bits, y counter is clog2(HEIGHT) bits; both are compared against WIDTH-1 and HEIGHT-1.

Decomposition:
- Shared include file (fb_defs.vh) holds:
  - state encoding localparams (IDLE, READ, DRAIN, DONE);
  - default geometry constants (WIDTH=160, HEIGHT=120, AW=15, DW=8);
  - FIFO depth constant 4.
- One sub-module: fb_read_fifo, a 4-entry synchronous FIFO of DW+2 bits with count output, push/pop, and async active-high reset.

Test Plan:
1. WIDTH=4, HEIGHT=2, BASE=0, RAM[i]=0x10+i, px_ready=1, start at t0:
   - addr_out 0..7 on consecutive cycles from t0+1;
   - px_data 0x10..0x17 from t0+3;
   - px_eol on 0x13 and 0x17; px_last on 0x17;
   - done pulse at t0+11; busy falls at t0+12.
2. Same image, px_ready pattern 1,0,0,1 repeating:
   - all 8 pixels delivered exactly once, in order;
   - outputs stable during stalls;
   - never more than 4 reserved FIFO slots.
3. start pulsed again mid-frame: ignored; pixel sequence and done timing unchanged.
4. rst asserted after the 3rd handshake:
   - all outputs 0 immediately;
   - after release and a new start, first pixel is 0x10 at addr 0.
5. BASE=100, WIDTH=4, HEIGHT=2: addr_out runs 100..107, and pixels RAM[100..107] are delivered in order.
6. Default 160x120 with px_ready=1:
   - 19200 handshakes in cycles t0+3 .. t0+19202;
   - exactly 120 px_eol and 1 px_last.

Source files
------------

// File: rtl/framebuffer_scan_reader_pkg.sv
// Shared definitions for the frame buffer scan reader: scan states,
// default geometry and read FIFO sizing.
package framebuffer_scan_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 120;
  localparam int DEF_AW     = 15;
  localparam int DEF_DW     = 8;

  localparam int FIFO_DEPTH = 4;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_scan_reader_checker.sv
// Simulation assertions for the scan reader: FIFO never overflows and the
// pixel stream holds still while stalled.
module fb_scan_checker #(
  parameter int DW = 8
) (
  input logic          clk,
  input logic          rst,
  input logic [2:0]    fifo_count,
  input logic          push,
  input logic          pop,
  input logic          px_valid,
  input logic          px_ready,
  input logic [DW-1:0] px_data,
  input logic          px_eol,
  input logic          px_last
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (({1'b0, fifo_count} - {3'b000, pop}) < 4'd4));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (px_valid && !px_ready) |=>
      (px_valid && $stable(px_data) && $stable(px_eol) && $stable(px_last)));

endmodule

// File: rtl/framebuffer_scan_reader_fb_read_fifo.sv
// Four-entry FIFO that absorbs the frame buffer read latency. The head entry
// is held in registers and reads as zero whenever the FIFO is empty.
module fb_read_fifo
  import framebuffer_scan_reader_pkg::*;
#(
  parameter int EW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [2:0]    count,
  output logic          rd_valid,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [1:0]    wr_ptr_r;
  logic [1:0]    rd_ptr_r;
  logic [2:0]    count_r;
  logic          head_valid_r;
  logic [EW-1:0] head_data_r;

  logic          pop_ok_s;
  logic          push_ok_s;
  logic [2:0]    after_pop_s;
  logic [2:0]    count_nxt_s;
  logic          head_valid_nxt_s;
  logic [EW-1:0] head_nxt_s;

  // Next occupancy and next head entry; a push into an empty FIFO shows up
  // at the head on the following cycle.
  always_comb begin
    pop_ok_s         = pop & head_valid_r;
    after_pop_s      = count_r - {2'b00, pop_ok_s};
    push_ok_s        = push & (after_pop_s != 3'd4);
    count_nxt_s      = after_pop_s + {2'b00, push_ok_s};
    head_valid_nxt_s = (count_nxt_s != 3'd0);
    if (count_nxt_s == 3'd0) begin
      head_nxt_s = {EW{1'b0}};
    end else if (after_pop_s == 3'd0) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_r + {1'b0, pop_ok_s}];
    end
  end

  // Storage array, no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= 2'd0;
      rd_ptr_r     <= 2'd0;
      count_r      <= 3'd0;
      head_valid_r <= 1'b0;
      head_data_r  <= {EW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r      <= count_nxt_s;
      head_valid_r <= head_valid_nxt_s;
      head_data_r  <= head_nxt_s;
    end
  end

  assign count    = count_r;
  assign rd_valid = head_valid_r;
  assign rd_data  = head_data_r;

endmodule

// File: rtl/framebuffer_scan_reader.sv
// Raster-order read master for the dual-port frame buffer; streams pixels
// downstream with end-of-line and end-of-frame flags.
module framebuffer_scan_reader
  import framebuffer_scan_reader_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int BASE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr_out,
  output logic          regread,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] px_data,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          px_eol,
  output logic          px_last
);

  localparam int XW = cnt_width(WIDTH);
  localparam int YW = cnt_width(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  if (longint'(BASE) + longint'(WIDTH) * longint'(HEIGHT) > (longint'(1) << AW))
  begin : g_bad_geometry
    $fatal(1, "framebuffer_scan_reader: image does not fit the address space");
  end

  scan_state_t   state_r;
  logic          busy_r;
  logic          done_r;
  logic          regread_r;
  logic [AW-1:0] addr_out_r;
  logic [AW-1:0] nxt_addr_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          iss_eol_r;
  logic          iss_last_r;
  logic          cap_r;
  logic          cap_eol_r;
  logic          cap_last_r;

  logic [2:0]    fifo_count_s;
  logic          fifo_valid_s;
  logic [DW+1:0] fifo_head_s;
  logic          pop_s;
  logic [3:0]    reserved_s;
  logic          issue_s;
  logic          at_eol_s;
  logic          at_last_s;

  // Reads are issued only while FIFO entries plus reads still in flight,
  // after this cycle's pop, leave room for one more.
  always_comb begin
    pop_s      = fifo_valid_s & px_ready;
    reserved_s = {1'b0, fifo_count_s} + {3'b000, cap_r} + {3'b000, regread_r}
               - {3'b000, pop_s};
    at_eol_s   = (x_r == X_LAST);
    at_last_s  = at_eol_s && (y_r == Y_LAST);
    if ((state_r == ST_READ) && (reserved_s < 4'd4)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Scan FSM, read issue, pixel position and capture pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      regread_r  <= 1'b0;
      addr_out_r <= {AW{1'b0}};
      nxt_addr_r <= {AW{1'b0}};
      x_r        <= {XW{1'b0}};
      y_r        <= {YW{1'b0}};
      iss_eol_r  <= 1'b0;
      iss_last_r <= 1'b0;
      cap_r      <= 1'b0;
      cap_eol_r  <= 1'b0;
      cap_last_r <= 1'b0;
    end else begin
      regread_r  <= issue_s;
      iss_eol_r  <= issue_s & at_eol_s;
      iss_last_r <= issue_s & at_last_s;
      cap_r      <= regread_r;
      cap_eol_r  <= iss_eol_r;
      cap_last_r <= iss_last_r;
      if (issue_s) begin
        addr_out_r <= nxt_addr_r;
        nxt_addr_r <= nxt_addr_r + AW'(1);
        if (at_eol_s) begin
          x_r <= {XW{1'b0}};
          y_r <= at_last_s ? {YW{1'b0}} : (y_r + YW'(1));
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= ST_READ;
            busy_r     <= 1'b1;
            nxt_addr_r <= AW'(BASE);
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
          end
        end
        ST_READ: begin
          if (issue_s && at_last_s) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop_s && fifo_head_s[DW+1]) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  fb_read_fifo #(.EW(DW + 2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_r),
    .push_data ({cap_last_r, cap_eol_r, data_in}),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .rd_valid  (fifo_valid_s),
    .rd_data   (fifo_head_s)
  );

  fb_scan_checker #(.DW(DW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .fifo_count (fifo_count_s),
    .push       (cap_r),
    .pop        (pop_s),
    .px_valid   (fifo_valid_s),
    .px_ready   (px_ready),
    .px_data    (fifo_head_s[DW-1:0]),
    .px_eol     (fifo_head_s[DW]),
    .px_last    (fifo_head_s[DW+1])
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign regread  = regread_r;
  assign addr_out = addr_out_r;
  assign px_valid = fifo_valid_s;
  assign px_data  = fifo_head_s[DW-1:0];
  assign px_eol   = fifo_head_s[DW];
  assign px_last  = fifo_head_s[DW+1];

endmodule

// File: tb/tb_framebuffer_scan_reader.sv
// Bench for framebuffer_scan_reader: three geometries share one stimulus
// driver, a frame buffer model and an index-based reference of the raster.
module tb_framebuffer_scan_reader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic px_ready;
  int   sel;

  int errors_cnt = 0;
  int checks_cnt = 0;

  logic        start_v    [3];
  logic        busy_v     [3];
  logic        done_v     [3];
  logic [14:0] addr_v     [3];
  logic        regread_v  [3];
  logic [7:0]  data_v     [3];
  logic [7:0]  px_data_v  [3];
  logic        px_valid_v [3];
  logic        px_eol_v   [3];
  logic        px_last_v  [3];

  logic        m_busy, m_done, m_regread, m_px_valid, m_px_eol, m_px_last;
  logic [14:0] m_addr;
  logic [7:0]  m_px_data;

  always #5 clk = ~clk;

  framebuffer_scan_reader #(.WIDTH(4), .HEIGHT(2), .BASE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .addr_out(addr_v[0]), .regread(regread_v[0]), .data_in(data_v[0]),
    .px_data(px_data_v[0]), .px_valid(px_valid_v[0]), .px_ready(px_ready),
    .px_eol(px_eol_v[0]), .px_last(px_last_v[0]));

  framebuffer_scan_reader #(.WIDTH(4), .HEIGHT(2), .BASE(100)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .addr_out(addr_v[1]), .regread(regread_v[1]), .data_in(data_v[1]),
    .px_data(px_data_v[1]), .px_valid(px_valid_v[1]), .px_ready(px_ready),
    .px_eol(px_eol_v[1]), .px_last(px_last_v[1]));

  framebuffer_scan_reader dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .addr_out(addr_v[2]), .regread(regread_v[2]), .data_in(data_v[2]),
    .px_data(px_data_v[2]), .px_valid(px_valid_v[2]), .px_ready(px_ready),
    .px_eol(px_eol_v[2]), .px_last(px_last_v[2]));

  function automatic logic [7:0] ram_byte(input int a);
    return 8'(16 + a);
  endfunction

  // Frame buffer model: one-cycle registered read per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (regread_v[i]) data_v[i] <= ram_byte(int'(addr_v[i]));
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) start_v[i] = start && (sel == i);
    m_busy     = busy_v[sel];
    m_done     = done_v[sel];
    m_addr     = addr_v[sel];
    m_regread  = regread_v[sel];
    m_px_data  = px_data_v[sel];
    m_px_valid = px_valid_v[sel];
    m_px_eol   = px_eol_v[sel];
    m_px_last  = px_last_v[sel];
  end

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_busy"}, m_busy, 0);
    chk_eq({tag, "_done"}, m_done, 0);
    chk_eq({tag, "_addr"}, m_addr, 0);
    chk_eq({tag, "_regread"}, m_regread, 0);
    chk_eq({tag, "_valid"}, m_px_valid, 0);
    chk_eq({tag, "_data"}, m_px_data, 0);
    chk_eq({tag, "_eol"}, m_px_eol, 0);
    chk_eq({tag, "_last"}, m_px_last, 0);
  endtask

  // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input int s, input int w, input int h, input int base,
                           input int mode, input bit mid_start, input int rst_at);
    int n = w * h;
    int k = 0;
    int issued = 0;
    int eol_cnt = 0;
    int last_cnt = 0;
    int last_cyc = -1;
    int limit = n * 4 + 40;
    bit prev_stall = 1'b0;
    bit hit_reset = 1'b0;
    sel = s;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 0; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (rst_at > 0 && k == rst_at) begin
        #1 rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        hit_reset = 1'b1;
        break;
      end
      start = mid_start && (cyc == 5);
      if (mode == 0) px_ready = 1'b1;
      else if (mode == 1) px_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else px_ready = ($urandom_range(0, 3) != 0);
      if (m_regread) begin
        chk_eq("rd_addr", m_addr, base + issued);
        issued++;
        chk_eq("reserved_le4", (issued - k) <= 4, 1);
      end
      if (mode == 0) begin
        chk_eq("rd_timing", m_regread, (cyc >= 1) && (cyc <= n));
        chk_eq("vld_timing", m_px_valid, (cyc >= 3) && (cyc < 3 + n));
      end
      if (prev_stall) chk_eq("vld_hold", m_px_valid, 1);
      if (m_px_valid && k < n) begin
        chk_eq("px_data", m_px_data, ram_byte(base + k));
        chk_eq("px_eol", m_px_eol, (k % w) == (w - 1));
        chk_eq("px_last", m_px_last, k == n - 1);
      end else if (m_px_valid) begin
        chk_eq("extra_px", m_px_valid, 0);
      end else begin
        chk_eq("idle_data", m_px_data, 0);
        chk_eq("idle_eol", m_px_eol, 0);
        chk_eq("idle_last", m_px_last, 0);
      end
      chk_eq("done", m_done, (last_cyc >= 0) && (cyc == last_cyc + 1));
      chk_eq("busy", m_busy, (last_cyc < 0) || (cyc <= last_cyc + 1));
      prev_stall = m_px_valid && !px_ready;
      if (m_px_valid && px_ready) begin
        eol_cnt  += int'(m_px_eol);
        last_cnt += int'(m_px_last);
        k++;
        if (k == n) last_cyc = cyc;
      end
      if (last_cyc >= 0 && cyc == last_cyc + 2) break;
    end
    start = 1'b0;
    px_ready = 1'b1;
    if (!hit_reset) begin
      chk_eq("px_count", k, n);
      chk_eq("rd_count", issued, n);
      chk_eq("eol_count", eol_cnt, h);
      chk_eq("last_count", last_cnt, 1);
      if (mode == 0) chk_eq("last_hs_cyc", last_cyc, n + 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    px_ready = 1'b1;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1 chk_all_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;

    run_frame(0, 4, 2, 0, 0, 1'b0, 0);
    run_frame(0, 4, 2, 0, 1, 1'b0, 0);
    run_frame(0, 4, 2, 0, 0, 1'b1, 0);
    run_frame(0, 4, 2, 0, 1, 1'b0, 3);
    run_frame(0, 4, 2, 0, 0, 1'b0, 0);
    for (int r = 0; r < 4; r++) run_frame(0, 4, 2, 0, 2, 1'b0, 0);
    run_frame(1, 4, 2, 100, 0, 1'b0, 0);
    run_frame(1, 4, 2, 100, 2, 1'b0, 0);
    run_frame(2, 160, 120, 0, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
